// File: rtl/sub_shift_stage_if.sv
// -----------------------------------------------------------------------------
// sub_shift_stage_if
// Handshake bundle around the SubBytes/ShiftRows stage: the upstream state
// channel (in_*) and the downstream transformed-state channel (out_*).
//   master : environment side (drives in_valid/in_state/out_ready)
//   slave  : stage side (drives in_ready/out_valid/out_state)
// Signals:
//   in_valid   upstream state valid
//   in_ready   stage can accept a state
//   in_state   128-bit AES state, byte i = in_state[127-8i -: 8]
//   out_valid  transformed state valid
//   out_ready  downstream accepts
//   out_state  transformed state, same byte ordering as in_state
// -----------------------------------------------------------------------------
interface sub_shift_stage_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;

    modport master (
        output in_valid,
        output in_state,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_state
    );

    modport slave (
        input  in_valid,
        input  in_state,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_state
    );
endinterface

// File: rtl/sub_shift_stage.sv
// -----------------------------------------------------------------------------
// sub_shift_stage
// Byte-serial AES round front end. Accepts one 128-bit state, streams its 16
// bytes through an external S-box (one per cycle), writes each returned byte
// into its ShiftRows position and presents the result downstream.
// Parameters:
//   SBOX_LAT  0 = combinational S-box, 1 = S-box with one output register
//   SHIFT_EN  1 = apply ShiftRows on write-back, 0 = write back in place
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   bus          handshake bundle (slave view)
//   sbox_byte_o  byte presented to the S-box (registered)
//   sbox_byte_i  S-box result
//   busy         high while bytes are being issued or drained
// Timing: out_valid rises 17+SBOX_LAT clocks after the accepting edge.
// -----------------------------------------------------------------------------
module sub_shift_stage #(
    parameter int SBOX_LAT = 0,
    parameter bit SHIFT_EN = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    sub_shift_stage_if.slave        bus,
    output logic [7:0]              sbox_byte_o,
    input  logic [7:0]              sbox_byte_i,
    output logic                    busy
);

    if ((SBOX_LAT != 32'sd0) && (SBOX_LAT != 32'sd1)) begin : g_bad_sbox_lat
        $error("sub_shift_stage: SBOX_LAT must be 0 or 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SUB   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t       state_q;
    logic [3:0]   rd_idx_q;
    logic [3:0]   wr_idx_q;
    logic [127:0] src_q;
    logic [127:0] res_q;
    logic [127:0] res_d;
    logic [127:0] out_state_q;
    logic         in_ready_q;
    logic         out_valid_q;
    logic         busy_q;
    logic [7:0]   sbox_byte_q;
    // iss_v_q[0]: sbox_byte_q holds a freshly issued byte; [1]: one cycle older
    logic [1:0]   iss_v_q;

    logic         cap_en_s;
    logic         last_cap_s;
    logic [3:0]   wr_dst_s;
    logic [6:0]   wr_base_s;
    logic [6:0]   rd_base_s;

    // MSB position of byte idx inside a 128-bit state (byte 0 is the top byte)
    function automatic logic [6:0] byte_base(input logic [3:0] idx);
        byte_base = 7'd127 - {idx, 3'b000};
    endfunction

    // Output position of source byte j: row r kept, column shifted left by r
    function automatic logic [3:0] wb_index(input logic [3:0] j);
        logic [1:0] r;
        logic [1:0] c;
        logic [1:0] dc;
        r  = j[1:0];
        c  = j[3:2];
        dc = c - r;                 // 2-bit wrap gives the mod-4 rotation
        if (SHIFT_EN) begin
            wb_index = {dc, r};
        end else begin
            wb_index = j;
        end
    endfunction

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_state = out_state_q;
    assign sbox_byte_o   = sbox_byte_q;
    assign busy          = busy_q;

    // Capture strobe: the S-box result is valid 1+SBOX_LAT cycles after issue
    always_comb begin
        cap_en_s   = (SBOX_LAT == 32'sd1) ? iss_v_q[1] : iss_v_q[0];
        last_cap_s = cap_en_s && (wr_idx_q == 4'd15);
        wr_dst_s   = wb_index(wr_idx_q);
        wr_base_s  = byte_base(wr_dst_s);
        rd_base_s  = byte_base(rd_idx_q);
    end

    // Next result buffer: merge the captured byte into its write-back slot
    always_comb begin
        res_d = res_q;
        if (cap_en_s) begin
            res_d[wr_base_s -: 8] = sbox_byte_i;
        end else begin
            res_d = res_q;
        end
    end

    // Capture datapath: issue-valid pipeline, write counter, result buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_v_q  <= 2'b00;
            wr_idx_q <= 4'd0;
            res_q    <= 128'd0;
        end else begin
            iss_v_q <= {iss_v_q[0], (state_q == ST_SUB)};
            res_q   <= res_d;
            if (cap_en_s) begin
                wr_idx_q <= wr_idx_q + 4'd1;   // wraps to 0 with the last capture
            end
        end
    end

    // Control FSM with registered handshake outputs and S-box issue register.
    // The issue register adds one stage, so even a combinational S-box leaves
    // one result in flight after the last issue; DRAIN absorbs it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rd_idx_q    <= 4'd0;
            src_q       <= 128'd0;
            out_state_q <= 128'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            sbox_byte_q <= 8'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        src_q      <= bus.in_state;
                        rd_idx_q   <= 4'd0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= ST_SUB;
                    end
                end
                ST_SUB: begin
                    sbox_byte_q <= src_q[rd_base_s -: 8];
                    rd_idx_q    <= rd_idx_q + 4'd1;
                    if (rd_idx_q == 4'd15) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (last_cap_s) begin
                        out_state_q <= res_d;
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
